// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared CPU memory port. The grant is held for a whole
// transaction, the response is routed back to its owner, and a bus timeout aborts hung transfers.
module mem_arbiter #(
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dtw,
  output logic [31:0] m0_dtr,
  input  logic        m0_rw,
  output logic        m0_err,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dtw,
  output logic [31:0] m1_dtr,
  input  logic        m1_rw,
  output logic        m1_err,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_dtw,
  input  logic [31:0] s_dtr,
  output logic        s_rw,
  output logic        grant,
  output logic        busy
);

  // Handshake: a master holds valid and its request stable until it sees a one-cycle
  // ready pulse. On the slave side a transfer completes in the cycle where
  // s_valid && s_ready; s_ready in any other cycle is ignored.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic        grant_q;
  logic        last_grant_q;
  logic [15:0] cnt_q;

  logic in_busy;
  logic gnt_valid;
  logic done;
  logic abort;
  logic fin;
  logic winner;

  assign in_busy   = (state_q == BUSY);
  assign gnt_valid = grant_q ? m1_valid : m0_valid;
  assign done      = in_busy & gnt_valid & s_ready;
  // A late s_ready on the timeout cycle still wins over the abort.
  assign abort     = in_busy & gnt_valid & ~s_ready & TO_EN & (cnt_q == CNT_LAST);
  assign fin       = done | abort;

  // Lone requester wins; on a tie m1 wins only in round-robin mode when m0 went last.
  assign winner = m1_valid & ~(m0_valid & (~RR_EN | last_grant_q));

  assign s_valid = in_busy & gnt_valid & ~abort;
  assign s_addr  = grant_q ? m1_addr : m0_addr;
  assign s_dtw   = grant_q ? m1_dtw  : m0_dtw;
  assign s_rw    = grant_q ? m1_rw   : m0_rw;

  assign m0_ready = fin & ~grant_q;
  assign m1_ready = fin & grant_q;
  assign m0_err   = abort & ~grant_q;
  assign m1_err   = abort & grant_q;
  assign m0_dtr   = abort ? 32'h0 : s_dtr;
  assign m1_dtr   = abort ? 32'h0 : s_dtr;

  assign grant = grant_q;
  assign busy  = in_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_valid | m1_valid) begin
            grant_q <= winner;
            cnt_q   <= 16'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (fin) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end else if (!gnt_valid) begin
            // Owner withdrew its request: abandon without a response or fairness update.
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance under directed and random traffic against a
// wait-state slave model, plus a fixed-priority instance for the tie-break rule.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // round-robin instance
  logic        m0_valid, m0_ready, m0_rw, m0_err;
  logic        m1_valid, m1_ready, m1_rw, m1_err;
  logic [31:0] m0_addr, m0_dtw, m0_dtr, m1_addr, m1_dtw, m1_dtr;
  logic        s_valid, s_ready, s_rw, grant, busy;
  logic [31:0] s_addr, s_dtw, s_dtr;

  // fixed-priority instance
  logic        f0_valid, f0_ready, f0_rw, f0_err;
  logic        f1_valid, f1_ready, f1_rw, f1_err;
  logic [31:0] f0_addr, f0_dtw, f0_dtr, f1_addr, f1_dtw, f1_dtr;
  logic        fs_valid, fs_ready, fs_rw, f_grant, f_busy;
  logic [31:0] fs_addr, fs_dtw, fs_dtr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
    logic        err;
    int          t;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] fq0[$];
  logic [31:0] fq1[$];
  int          log_m[$];
  int          log_c[$];
  int          f_log[$];

  logic        stall = 1'b0;
  logic        noise = 1'b0;
  logic [15:0] slv_cnt = 16'd0;

  mem_arbiter #(.RR_EN(1'b1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_dtw(m0_dtw),
    .m0_dtr(m0_dtr), .m0_rw(m0_rw), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_dtw(m1_dtw),
    .m1_dtr(m1_dtr), .m1_rw(m1_rw), .m1_err(m1_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_dtw(s_dtw),
    .s_dtr(s_dtr), .s_rw(s_rw), .grant(grant), .busy(busy)
  );

  mem_arbiter #(.RR_EN(1'b0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .reset(reset),
    .m0_valid(f0_valid), .m0_ready(f0_ready), .m0_addr(f0_addr), .m0_dtw(f0_dtw),
    .m0_dtr(f0_dtr), .m0_rw(f0_rw), .m0_err(f0_err),
    .m1_valid(f1_valid), .m1_ready(f1_ready), .m1_addr(f1_addr), .m1_dtw(f1_dtw),
    .m1_dtr(f1_dtr), .m1_rw(f1_rw), .m1_err(f1_err),
    .s_valid(fs_valid), .s_ready(fs_ready), .s_addr(fs_addr), .s_dtw(fs_dtw),
    .s_dtr(fs_dtr), .s_rw(fs_rw), .grant(f_grant), .busy(f_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=still running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- slave models ----------------
  // Read data is a fixed function of the address; the wait (in BUSY cycles) is addr[3:0].
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  always @(posedge clk) begin
    slv_cnt <= busy ? slv_cnt + 16'd1 : 16'd0;
    noise   <= 1'($urandom_range(0, 1));
  end
  assign s_ready  = busy ? (~stall && slv_cnt == {12'd0, s_addr[3:0]}) : noise;
  assign s_dtr    = data_of(s_addr);
  assign fs_ready = f_busy;
  assign fs_dtr   = data_of(fs_addr);

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp_v);
    end
  endtask

  task automatic score(input int m, input logic err, input logic [31:0] dtr);
    exp_t e;
    int   mn;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_ready_m%0d act=ready exp=no ready", m);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    chk1("err", err, e.err);
    chk("dtr", dtr, e.err ? 32'h0 : data_of(e.addr));
    chk1("grant", grant, m[0]);
    if (e.err) begin
      chk1("s_valid_on_abort", s_valid, 1'b0);
      mn = TO;
    end else begin
      chk1("s_valid", s_valid, 1'b1);
      chk("s_addr", s_addr, e.addr);
      chk("s_dtw", s_dtw, e.dtw);
      chk1("s_rw", s_rw, e.rw);
      mn = int'(e.addr[3:0]) + 1;
    end
    chk1("latency_min", (cyc - e.t) >= mn, 1'b1);
    log_m.push_back(m);
    log_c.push_back(cyc);
  endtask

  // ---------------- monitors ----------------
  logic idle_chk = 1'b0;
  always @(negedge clk) begin
    if (idle_chk) begin
      chk1("idle_after_done", busy, 1'b0);
      idle_chk = 1'b0;
    end
    if (m0_ready === 1'b1 || m1_ready === 1'b1 || m0_err === 1'b1 || m1_err === 1'b1) begin
      chk1("dual_ready", m0_ready & m1_ready, 1'b0);
      chk("err_without_ready", {30'd0, m1_err & ~m1_ready, m0_err & ~m0_ready}, 32'd0);
      if (m0_ready === 1'b1) score(0, m0_err, m0_dtr);
      if (m1_ready === 1'b1) score(1, m1_err, m1_dtr);
      idle_chk = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (f0_ready === 1'b1) begin
      if (fq0.size() == 0) chk1("fp_unexpected_m0", 1'b1, 1'b0);
      else chk("fp_dtr0", f0_dtr, data_of(fq0.pop_front()));
      chk1("fp_err0", f0_err, 1'b0);
      f_log.push_back(0);
    end
    if (f1_ready === 1'b1) begin
      if (fq1.size() == 0) chk1("fp_unexpected_m1", 1'b1, 1'b0);
      else chk("fp_dtr1", f1_dtr, data_of(fq1.pop_front()));
      chk1("fp_err1", f1_err, 1'b0);
      f_log.push_back(1);
    end
  end

  // ---------------- drivers ----------------
  task automatic do_xfer(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic rw, output int t_iss);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_valid = 1'b1; m0_addr = a; m0_dtw = d; m0_rw = rw;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_dtw = d; m1_rw = rw;
    end
    e.addr = a; e.dtw = d; e.rw = rw; e.t = cyc;
    e.err  = stall | (a[3:0] > 4'd7);
    t_iss  = cyc;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (m == 0) ? (m0_ready === 1'b1) : (m1_ready === 1'b1);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_ready_m%0d act=no ready exp=ready within 200 cycles", m);
    end
  endtask

  task automatic rel(input int m);
    @(posedge clk);
    #1;
    if (m == 0) m0_valid = 1'b0;
    else m1_valid = 1'b0;
  endtask

  task automatic wait_f(input int m);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (m == 0) ? (f0_ready === 1'b1) : (f1_ready === 1'b1);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL fp_wait_ready_m%0d act=no ready exp=ready within 200 cycles", m);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    m0_valid = 1'b0; m1_valid = 1'b0; f0_valid = 1'b0; f1_valid = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    log_m.delete(); log_c.delete(); f_log.delete();
  endtask

  task automatic tie_m0_first(input string nm, input logic [31:0] base);
    int ta, tb;
    log_m.delete(); log_c.delete();
    fork
      begin do_xfer(0, base, 32'h11, 1'b0, ta); rel(0); end
      begin do_xfer(1, base + 32'h10, 32'h22, 1'b1, tb); rel(1); end
    join
    chk(nm, log_m.size() > 0 ? log_m[0] : -1, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    reset = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_dtw = '0; m0_rw = 1'b0;
    m1_valid = 1'b0; m1_addr = '0; m1_dtw = '0; m1_rw = 1'b0;
    f0_valid = 1'b0; f0_addr = '0; f0_dtw = '0; f0_rw = 1'b0;
    f1_valid = 1'b0; f1_addr = '0; f1_dtw = '0; f1_rw = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_grant", grant, 1'b0);
    chk1("rst_s_valid", s_valid, 1'b0);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_err", {30'd0, m1_err, m0_err}, 32'd0);

    // single zero-wait read by fetch
    log_m.delete(); log_c.delete();
    do_xfer(0, 32'h100, 32'h0, 1'b0, t);
    rel(0);
    chk("t1_count", log_m.size(), 1);
    if (log_m.size() == 1) chk("t1_latency", log_c[0] - t, 1);

    // both requesting from reset, round-robin, zero wait
    do_reset();
    fork
      begin
        int ta;
        for (int i = 0; i < 4; i++) do_xfer(0, 32'h1000 + 32'(i * 16), $urandom, 1'b0, ta);
        rel(0);
      end
      begin
        int tb;
        for (int i = 0; i < 4; i++) do_xfer(1, 32'h2000 + 32'(i * 16), $urandom, 1'b1, tb);
        rel(1);
      end
    join
    chk("rr_count", log_m.size(), 8);
    if (log_m.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("rr_order", log_m[i], i % 2);
      for (int i = 1; i < 8; i++) chk("rr_spacing", log_c[i] - log_c[i - 1], 2);
    end

    // fixed priority: fetch keeps requesting, load/store waits until fetch is quiet
    do_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(posedge clk);
          #1 f0_valid = 1'b1; f0_addr = 32'h400 + 32'(i * 16); f0_dtw = $urandom; f0_rw = 1'b0;
          fq0.push_back(f0_addr);
          wait_f(0);
        end
        @(posedge clk);
        #1 f0_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(posedge clk);
          #1 f1_valid = 1'b1; f1_addr = 32'h800 + 32'(i * 16); f1_dtw = $urandom; f1_rw = 1'b1;
          fq1.push_back(f1_addr);
          wait_f(1);
        end
        @(posedge clk);
        #1 f1_valid = 1'b0;
      end
    join
    chk("fp_count", f_log.size(), 8);
    if (f_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("fp_order", f_log[i], (i < 4) ? 0 : 1);

    // load/store write against a memory that never answers
    do_reset();
    log_m.delete(); log_c.delete();
    stall = 1'b1;
    do_xfer(1, 32'h2000, 32'h55AA, 1'b1, t);
    rel(1);
    stall = 1'b0;
    chk("t4_count", log_m.size(), 1);
    if (log_m.size() == 1) chk("t4_latency", log_c[0] - t, TO);

    // answer arrives exactly on the timeout cycle
    log_m.delete(); log_c.delete();
    do_xfer(1, 32'h2007, 32'h1234, 1'b1, t);
    rel(1);
    chk("t5_count", log_m.size(), 1);
    if (log_m.size() == 1) chk("t5_latency", log_c[0] - t, TO);

    // reset in the middle of a stalled transfer
    do_reset();
    stall = 1'b1;
    @(posedge clk);
    #1 m0_valid = 1'b1; m0_addr = 32'h300; m0_rw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("pre_reset_busy", busy, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("mid_reset_busy", busy, 1'b0);
    chk1("mid_reset_s_valid", s_valid, 1'b0);
    chk("mid_reset_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; m0_valid = 1'b0; stall = 1'b0;
    tie_m0_first("tie_after_reset", 32'h3100);

    // owner withdraws its request while the memory is stalled
    do_reset();
    stall = 1'b1;
    @(posedge clk);
    #1 m0_valid = 1'b1; m0_addr = 32'h500; m0_rw = 1'b0;
    repeat (2) @(posedge clk);
    #1 m0_valid = 1'b0;
    @(negedge clk);
    chk1("drop_s_valid", s_valid, 1'b0);
    chk1("drop_still_busy", busy, 1'b1);
    @(negedge clk);
    chk1("drop_idle", busy, 1'b0);
    stall = 1'b0;
    tie_m0_first("tie_after_drop", 32'h5100);

    // random traffic from both requesters, waits 0..15 (waits above 7 time out)
    fork
      begin
        int ta;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_xfer(0, $urandom, $urandom, 1'($urandom_range(0, 1)), ta);
          rel(0);
        end
      end
      begin
        int tb;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_xfer(1, $urandom, $urandom, 1'($urandom_range(0, 1)), tb);
          rel(1);
        end
      end
    join
    repeat (4) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("fq_drained", fq0.size() + fq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
